// File: rtl/hnf_link_txreq_arb.sv
// hnf_link_txreq_arb
// ------------------
// HN-F TXREQ link transmitter. Arbitrates NUM_SRC request sources with a
// two-class QoS priority and round-robin fairness, tracks CHI L-credits in a
// saturating counter, and drives the registered TXREQ flit interface. On link
// deactivation every held credit is handed back as an all-zero ReqLCrdReturn
// flit before link_drained is raised.
//
// Handshake: a source asserts src_valid[i] with src_flit/src_qos stable and
// holds them until src_won[i] is seen high in the same cycle; the grant is
// the transfer (no separate ready). A source may withdraw without a grant.
// The link side is credit based: txreq_lcrdv gives one credit per cycle and
// each txreqflitv consumes one.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   txreq_lcrdv       one L-credit granted by the link this cycle
//   link_en           1 = run link, 0 = deactivate
//   src_valid         per-source request
//   src_qos           per-source QoS, source i at [i*QOS_WIDTH +: QOS_WIDTH]
//   src_flit          per-source flit, source i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//   src_won           one-hot grant, combinational
//   txreqflitv        registered flit valid
//   txreqflit         registered flit
//   txreqflitpend     tied high
//   txreq_crd_cnt     current credit count
//   link_drained      registered, high while in IDLE
//   crd_ovf_err       sticky credit-overflow error
//   dbg_state         current FSM state (0 IDLE, 1 ACTIVE, 2 RETURN)

`ifndef CHIE_REQ_FLIT_WIDTH
`define CHIE_REQ_FLIT_WIDTH 151
`endif

module hnf_link_txreq_arb #(
  parameter int                   NUM_SRC       = 4,
  parameter int                   FLIT_WIDTH    = `CHIE_REQ_FLIT_WIDTH,
  parameter int                   QOS_WIDTH     = 4,
  parameter logic [QOS_WIDTH-1:0] QOS_HI_THRESH = 4'd12,
  parameter int                   LCRD_MAX      = 15,
  parameter int                   CNT_WIDTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          txreq_lcrdv,
  input  logic                          link_en,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*QOS_WIDTH-1:0]  src_qos,
  input  logic [NUM_SRC*FLIT_WIDTH-1:0] src_flit,
  output logic [NUM_SRC-1:0]            src_won,
  output logic                          txreqflitv,
  output logic [FLIT_WIDTH-1:0]         txreqflit,
  output logic                          txreqflitpend,
  output logic [CNT_WIDTH-1:0]          txreq_crd_cnt,
  output logic                          link_drained,
  output logic                          crd_ovf_err,
  output logic [1:0]                    dbg_state
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RETURN = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [PTR_W-1:0]     rr_ptr;
  logic                 crd_avail;
  logic                 arb_en;
  logic [NUM_SRC-1:0]   hi_req;
  logic [NUM_SRC-1:0]   compete;
  logic [NUM_SRC-1:0]   grant;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     cand;
  logic                 found;
  logic [FLIT_WIDTH-1:0] sel_flit;
  logic                 send_req;
  logic                 send_ret;
  logic                 sent;

  assign txreqflitpend = 1'b1;
  assign dbg_state     = state;

  // A credit arriving this cycle can be spent in the same cycle.
  assign crd_avail = (txreq_crd_cnt != '0) | txreq_lcrdv;
  assign arb_en    = (state == ST_ACTIVE) & crd_avail;

  // QoS class split, then round-robin search starting at rr_ptr.
  always_comb begin
    hi_req    = '0;
    compete   = '0;
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hi_req[i] = src_valid[i] &
                  (src_qos[i*QOS_WIDTH +: QOS_WIDTH] >= QOS_HI_THRESH);
    end
    compete = (|hi_req) ? hi_req : src_valid;
    if (arb_en) begin
      for (int off = 0; off < NUM_SRC; off++) begin
        cand = PTR_W'((int'(rr_ptr) + off) % NUM_SRC);
        if (!found && compete[cand]) begin
          grant[cand] = 1'b1;
          grant_idx   = cand;
          found       = 1'b1;
        end
      end
    end
  end

  assign src_won = grant;

  always_comb begin
    sel_flit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) sel_flit = src_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
    end
  end

  assign send_req = found;
  assign send_ret = (state == ST_RETURN) & crd_avail;
  assign sent     = send_req | send_ret;

  // Next-state logic. RETURN only exits once nothing is held and nothing
  // is arriving, so a late credit is still handed back.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (link_en) state_next = ST_ACTIVE;
      ST_ACTIVE: if (!link_en) state_next = ST_RETURN;
      ST_RETURN: if ((txreq_crd_cnt == '0) && !txreq_lcrdv) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      txreqflitv   <= 1'b0;
      txreqflit    <= '0;
      txreq_crd_cnt <= '0;
      link_drained <= 1'b1;
      crd_ovf_err  <= 1'b0;
    end else begin
      state        <= state_next;
      link_drained <= (state_next == ST_IDLE);

      if (send_req) begin
        rr_ptr <= (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + PTR_W'(1);
      end

      txreqflitv <= sent;
      if (send_req) begin
        txreqflit <= sel_flit;
      end else if (send_ret) begin
        txreqflit <= '0;
      end

      // Credit in and credit out in the same cycle cancel.
      if (txreq_lcrdv && !sent) begin
        if (txreq_crd_cnt == CNT_WIDTH'(LCRD_MAX)) begin
          crd_ovf_err <= 1'b1;
        end else begin
          txreq_crd_cnt <= txreq_crd_cnt + CNT_WIDTH'(1);
        end
      end else if (sent && !txreq_lcrdv) begin
        txreq_crd_cnt <= txreq_crd_cnt - CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_hnf_link_txreq_arb.sv
module tb_hnf_link_txreq_arb;

  localparam int N    = 4;
  localparam int FW   = 16;
  localparam int QW   = 4;
  localparam int CW   = 4;
  localparam int LMAX = 15;
  localparam int HI   = 12;

  localparam int M_IDLE   = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_RETURN = 2;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            txreq_lcrdv;
  logic            link_en;
  logic [N-1:0]    src_valid;
  logic [N*QW-1:0] src_qos;
  logic [N*FW-1:0] src_flit;
  logic [N-1:0]    src_won;
  logic            txreqflitv;
  logic [FW-1:0]   txreqflit;
  logic            txreqflitpend;
  logic [CW-1:0]   txreq_crd_cnt;
  logic            link_drained;
  logic            crd_ovf_err;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  hnf_link_txreq_arb #(
    .NUM_SRC(N), .FLIT_WIDTH(FW), .QOS_WIDTH(QW),
    .QOS_HI_THRESH(4'd12), .LCRD_MAX(LMAX), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .txreq_lcrdv(txreq_lcrdv), .link_en(link_en),
    .src_valid(src_valid), .src_qos(src_qos), .src_flit(src_flit),
    .src_won(src_won), .txreqflitv(txreqflitv), .txreqflit(txreqflit),
    .txreqflitpend(txreqflitpend), .txreq_crd_cnt(txreq_crd_cnt),
    .link_drained(link_drained), .crd_ovf_err(crd_ovf_err),
    .dbg_state(dbg_state)
  );

  // ---------------- behavioural model ----------------
  int            m_state   = M_IDLE;
  int            m_cnt     = 0;
  int            m_ptr     = 0;
  bit            m_ovf     = 1'b0;
  bit            m_flitv   = 1'b0;
  bit            m_drained = 1'b1;
  logic [FW-1:0] m_flit    = '0;
  logic [FW-1:0] exp_q[$];

  int            checks = 0;
  int            errors = 0;
  logic [N-1:0]  last_won;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int qos_of(input int i);
    logic [N*QW-1:0] q;
    q = src_qos;
    return int'(q[i*QW +: QW]);
  endfunction

  // Winner by the QoS/round-robin rules; -1 when nobody may win.
  function automatic int model_pick();
    bit any_hi;
    int idx;
    any_hi = 1'b0;
    if (m_state != M_ACTIVE) return -1;
    if (m_cnt == 0 && !txreq_lcrdv) return -1;
    for (int i = 0; i < N; i++)
      if (src_valid[i] && qos_of(i) >= HI) any_hi = 1'b1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (src_valid[idx] && (!any_hi || qos_of(idx) >= HI)) return idx;
    end
    return -1;
  endfunction

  // One clock: inputs already driven at the falling edge.
  task automatic tick();
    int            gi;
    int            old_cnt;
    bit            sent;
    logic [N-1:0]  exp_won;
    logic [N*FW-1:0] fl;
    #1;
    gi      = model_pick();
    exp_won = '0;
    if (gi >= 0) exp_won[gi] = 1'b1;
    last_won = src_won;
    check("src_won", src_won, exp_won);
    @(posedge clk);
    if (rst) begin
      m_state = M_IDLE; m_cnt = 0; m_ptr = 0; m_ovf = 0;
      m_flitv = 0; m_flit = '0; m_drained = 1;
      exp_q.delete();
    end else begin
      old_cnt = m_cnt;
      sent    = 1'b0;
      fl      = src_flit;
      if (gi >= 0) begin
        sent   = 1'b1;
        m_flit = fl[gi*FW +: FW];
        m_ptr  = (gi + 1) % N;
        exp_q.push_back(m_flit);
      end else if (m_state == M_RETURN && (m_cnt != 0 || txreq_lcrdv)) begin
        sent   = 1'b1;
        m_flit = '0;
        exp_q.push_back(m_flit);
      end
      m_flitv = sent;
      if (txreq_lcrdv && !sent) begin
        if (m_cnt == LMAX) m_ovf = 1'b1;
        else m_cnt++;
      end else if (sent && !txreq_lcrdv) begin
        m_cnt--;
      end
      case (m_state)
        M_IDLE:   if (link_en) m_state = M_ACTIVE;
        M_ACTIVE: if (!link_en) m_state = M_RETURN;
        default:  if (old_cnt == 0 && !txreq_lcrdv) m_state = M_IDLE;
      endcase
      m_drained = (m_state == M_IDLE);
    end
    #1;
    check("txreqflitv", txreqflitv, m_flitv);
    check("txreqflit", txreqflit, m_flit);
    check("txreq_crd_cnt", txreq_crd_cnt, m_cnt);
    check("link_drained", link_drained, m_drained);
    check("crd_ovf_err", crd_ovf_err, m_ovf);
    check("txreqflitpend", txreqflitpend, 1'b1);
    if (txreqflitv === 1'b1) begin
      if (exp_q.size() == 0) check("flit_order_extra", 1'b1, 1'b0);
      else check("flit_order", txreqflit, exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive(input bit lcrd, input bit en, input logic [N-1:0] v);
    txreq_lcrdv = lcrd;
    link_en     = en;
    src_valid   = v;
  endtask

  task automatic set_qos(input int i, input int q);
    src_qos[i*QW +: QW] = QW'(q);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int nflits;
    bit drained_seen;
    rst = 1'b1;
    drive(0, 0, '0);
    src_qos  = '0;
    for (int i = 0; i < N; i++) src_flit[i*FW +: FW] = FW'(16'hA000 + i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    tick();

    // reset values
    check("rst_cnt", txreq_crd_cnt, 4'd0);
    check("rst_drained", link_drained, 1'b1);
    check("rst_flitv", txreqflitv, 1'b0);
    check("rst_ovf", crd_ovf_err, 1'b0);
    rst = 1'b0;

    // three credits, then four equal-class requests
    drive(1, 1, '0);
    repeat (3) tick();
    check("crd_three", txreq_crd_cnt, 4'd3);
    drive(0, 1, 4'b1111);
    tick(); check("rr_g0", last_won, 4'b0001); src_valid &= ~last_won;
    tick(); check("rr_g1", last_won, 4'b0010); src_valid &= ~last_won;
    tick(); check("rr_g2", last_won, 4'b0100); src_valid &= ~last_won;
    check("crd_zero", txreq_crd_cnt, 4'd0);
    tick(); check("rr_wait", last_won, 4'b0000);
    txreq_lcrdv = 1'b1;
    tick(); check("rr_g3", last_won, 4'b1000);
    check("g3_flit", txreqflit, 16'hA003);
    check("g3_cnt", txreq_crd_cnt, 4'd0);

    // same-cycle credit use with count 0
    drive(1, 1, 4'b0010);
    tick(); check("bypass_won", last_won, 4'b0010);
    check("bypass_flitv", txreqflitv, 1'b1);
    check("bypass_flit", txreqflit, 16'hA001);
    check("bypass_cnt", txreq_crd_cnt, 4'd0);

    // high class wins repeatedly over low class
    set_qos(0, 2); set_qos(2, 13);
    drive(1, 1, 4'b0101);
    repeat (3) begin tick(); check("hi_wins", last_won, 4'b0100); end
    src_valid = 4'b0001;
    tick(); check("lo_after_hi", last_won, 4'b0001);
    src_qos = '0;

    // saturation
    drive(1, 1, '0);
    repeat (15) tick();
    check("sat_cnt", txreq_crd_cnt, 4'd15);
    check("sat_no_ovf", crd_ovf_err, 1'b0);
    tick();
    check("ovf_cnt", txreq_crd_cnt, 4'd15);
    check("ovf_set", crd_ovf_err, 1'b1);
    drive(0, 1, '0);
    repeat (3) tick();
    check("ovf_sticky", crd_ovf_err, 1'b1);

    // spend down to 5, then deactivate with one late credit
    drive(0, 1, 4'b0001);
    repeat (10) tick();
    check("pre_drain_cnt", txreq_crd_cnt, 4'd5);
    drive(0, 0, '0);
    tick();
    nflits = 0;
    drained_seen = 1'b0;
    for (int r = 0; r < 30 && !drained_seen; r++) begin
      txreq_lcrdv = (r == 2);
      tick();
      if (txreqflitv === 1'b1 && txreqflit === 16'h0000) nflits++;
      if (link_drained === 1'b1) drained_seen = 1'b1;
    end
    txreq_lcrdv = 1'b0;
    check("drain_seen", drained_seen, 1'b1);
    check("drain_flits", nflits, 6);
    check("drain_cnt", txreq_crd_cnt, 4'd0);

    // reset in the middle of a return
    drive(1, 1, '0);
    repeat (5) tick();
    drive(0, 0, '0);
    repeat (3) tick();
    check("ret_cnt3", txreq_crd_cnt, 4'd3);
    check("ret_busy", link_drained, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_cnt", txreq_crd_cnt, 4'd0);
    check("mid_rst_flitv", txreqflitv, 1'b0);
    check("mid_rst_drained", link_drained, 1'b1);
    check("mid_rst_ovf", crd_ovf_err, 1'b0);

    // randomized traffic
    link_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      txreq_lcrdv = $urandom_range(0, 1);
      if ($urandom_range(0, 39) == 0) link_en = ~link_en;
      src_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        set_qos(i, $urandom_range(0, 15));
        src_flit[i*FW +: FW] = FW'($urandom_range(0, 65535));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hnf_link_txreq_arb.md
# hnf_link_txreq_arb

Parametrised HN-F TXREQ link transmitter for the next HN-F generation. It arbitrates among NUM_SRC request sources (MSHR fast path, MSHR control, and future sources such as prefetch or eviction engines) with two-class QoS priority and round-robin fairness. It tracks CHI L-credits with a saturating counter and drives the registered TXREQ flit interface toward hnf_link. It also runs link deactivation: all held credits are returned as ReqLCrdReturn flits before the link is reported drained.

## Interface
Parameters:
- NUM_SRC, 4: number of request sources (2..8).
- FLIT_WIDTH, `CHIE_REQ_FLIT_WIDTH: request flit width.
- QOS_WIDTH, 4: QoS field width.
- QOS_HI_THRESH, 4'd12: QoS at or above this value is high class.
- LCRD_MAX, 15: maximum L-credits held.
- CNT_WIDTH, 4: credit counter width, ≥ clog2(LCRD_MAX+1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- txreq_lcrdv  in  1  one L-credit granted by the link this cycle.
- link_en  in  1  1 = link run requested; 0 = deactivate.
- src_valid  in  NUM_SRC  per-source request.
- src_qos  in  NUM_SRC*QOS_WIDTH  per-source QoS; source i at [i*QOS_WIDTH +: QOS_WIDTH].
- src_flit  in  NUM_SRC*FLIT_WIDTH  per-source fully formed flit; source i at [i*FLIT_WIDTH +: FLIT_WIDTH].
- src_won  out  NUM_SRC  one-hot grant, combinational, same cycle as request.
- txreqflitv  out  1  registered flit valid.
- txreqflit  out  FLIT_WIDTH  registered flit.
- txreqflitpend  out  1  tied 1.
- txreq_crd_cnt  out  CNT_WIDTH  current credit count (status).
- link_drained  out  1  registered; 1 in IDLE state.
- crd_ovf_err  out  1  sticky credit-overflow error.

## Operation
- States: ACTIVE, RETURN, IDLE. Reset state is IDLE.
- IDLE → ACTIVE when link_en=1. ACTIVE → RETURN when link_en=0. RETURN → IDLE when the count is 0 and txreq_lcrdv=0.
- A link_en rise during RETURN is ignored until IDLE is reached; ACTIVE is entered the following cycle if link_en is still 1.
- crd_avail = (txreq_crd_cnt != 0) | txreq_lcrdv. An incoming credit is usable in the cycle it arrives.
- Arbitration runs only in ACTIVE with crd_avail=1.
  - If any valid source is high class, only high-class sources compete; otherwise all valid sources compete.
  - Round-robin within the competing set, starting at rr_ptr.
  - On a grant to source i, rr_ptr ← (i+1) mod NUM_SRC. rr_ptr is unchanged without a grant.
  - src_won is all-zero when not ACTIVE or crd_avail=0.
- Send in ACTIVE: a grant to source i sets txreqflit ← src_flit[i] and txreqflitv ← 1.
- Send in RETURN: each cycle with crd_avail=1, emit an all-zero flit (opcode ReqLCrdReturn = 0) with txreqflitv ← 1.
- Otherwise txreqflitv ← 0 and txreqflit holds its last value.
- Counter update (inc = txreq_lcrdv, dec = a flit sent this cycle):
  - inc only: +1.
  - dec only: −1.
  - both: hold.
  - neither: hold.
- Saturation: inc only with count == LCRD_MAX → count holds at LCRD_MAX and crd_ovf_err ← 1. crd_ovf_err clears only on rst.
- Reset values: txreqflitv 0, txreqflit 0, txreq_crd_cnt 0, link_drained 1, crd_ovf_err 0, rr_ptr 0, state IDLE.

## Timing
- Request to src_won: 0 cycles (combinational). Request to txreqflitv: 1 cycle.
- Sustained throughput of 1 flit/cycle while credits last. With count 0, a flit is sent only in a cycle where txreq_lcrdv=1.
- A source must hold src_valid and src_flit until src_won. A source may drop its request without a grant; no state is kept for it.
- link_en=0 in the same cycle as a pending request: the state is still ACTIVE that cycle, so the grant proceeds. The transition to RETURN takes effect the next cycle.
- rst mid-operation discards the count and any in-flight return. The link layer must restart its credit handshake.

## Test plan
- Reset, link_en=1, 3 credits, then src_valid=4'b1111 with all QoS 0 → grants 0,1,2 on consecutive cycles; count 3→0; source 3 waits until the next lcrdv, then is granted with rr_ptr=3→0.
- Count 0, lcrdv and src_valid[1] in the same cycle → src_won=4'b0010 that cycle; flit out next cycle; count stays 0.
- src_valid=4'b0101, qos[0]=2, qos[2]=13 → source 2 wins repeatedly; source 0 is granted only once source 2 drops.
- Count 15, lcrdv without a send → count 15, crd_ovf_err=1; it persists until rst.
- Count 5, link_en 1→0 → 5 consecutive all-zero flits, count 5→0, link_drained=1 the cycle after; an lcrdv arriving mid-return is also returned (6 flits total).
- rst asserted during RETURN with count 3 → next cycle count 0, txreqflitv 0, state IDLE, link_drained 1.
